// File: rtl/lsu_access_unit.sv
// lsu_access_unit: turns one decoded load/store into a single word-aligned
// bus transaction (valid/ready on both sides). It steers store lanes and
// builds write strobes, and it extracts and extends load data. Results go to
// writeback with an error flag.
// Optional build macro: LSU_MISALIGN_CHECK_EN. When defined, misaligned
// half/word accesses fail with out_err and issue no bus request.
module lsu_access_unit #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mren,
    input  logic [1:0]        in_mwen,
    input  logic              in_unsign,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_rdata,
    output logic              out_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        mren_q, mren_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_valid_q, req_valid_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_val;
    logic [31:0]       rsp_val;
    logic [1:0]        acc_size;
    logic              misalign;
    logic [CNT_W-1:0]  cnt_inc;
    logic              timeout_hit;

    assign in_ready      = (state_q == IDLE);
    assign mem_req_valid = req_valid_q;
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wstrb     = wstrb_q;
    assign out_valid     = out_valid_q;
    assign out_rdata     = rdata_q;
    assign out_err       = err_q;

    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
    // Stores return zero; loads return the extended lane.
    assign rsp_val     = we_q ? 32'h0 : load_val;

    // Lane extraction and sign/zero extension of the raw read word
    always_comb begin
        case (off_q)
            2'd0:    rd_byte = mem_rdata[7:0];
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (mren_q)
            2'b01:   load_val = uns_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b10:   load_val = uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            2'b11:   load_val = mem_rdata;
            default: load_val = 32'h0;
        endcase
    end

    // Alignment check on the incoming op (only one of mren/mwen is nonzero when used)
    always_comb begin
        acc_size = in_mren | in_mwen;
`ifdef LSU_MISALIGN_CHECK_EN
        misalign = ((acc_size == 2'b10) && in_addr[0]) ||
                   ((acc_size == 2'b11) && (in_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        mren_d      = mren_q;
        uns_d       = uns_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        req_valid_d = req_valid_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        out_valid_d = out_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mren_d = in_mren;
                    uns_d  = in_unsign;
                    off_d  = in_addr[1:0];
                    if ((in_mren != 2'b00) && (in_mwen != 2'b00)) begin
                        state_d = DONE; out_valid_d = 1'b1; rdata_d = 32'h0; err_d = 1'b1;
                    end else if ((in_mren == 2'b00) && (in_mwen == 2'b00)) begin
                        state_d = DONE; out_valid_d = 1'b1; rdata_d = 32'h0; err_d = 1'b0;
                    end else if (misalign) begin
                        state_d = DONE; out_valid_d = 1'b1; rdata_d = 32'h0; err_d = 1'b1;
                    end else begin
                        state_d     = REQ;
                        req_valid_d = 1'b1;
                        we_d        = (in_mwen != 2'b00);
                        addr_d      = {in_addr[ADDR_W-1:2], 2'b00};
                        case (in_mwen)
                            2'b01: begin
                                wstrb_d = 4'b0001 << in_addr[1:0];
                                wdata_d = {4{in_wdata[7:0]}};
                            end
                            2'b10: begin
                                wstrb_d = 4'b0011 << {in_addr[1], 1'b0};
                                wdata_d = {2{in_wdata[15:0]}};
                            end
                            2'b11: begin
                                wstrb_d = 4'b1111;
                                wdata_d = in_wdata;
                            end
                            default: begin
                                wstrb_d = 4'b0000;
                                wdata_d = in_wdata;
                            end
                        endcase
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    req_valid_d = 1'b0;
                    cnt_d       = '0;
                    if (mem_rsp_valid) begin
                        state_d = DONE; out_valid_d = 1'b1; rdata_d = rsp_val; err_d = 1'b0;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_inc;
                if (mem_rsp_valid) begin
                    state_d = DONE; out_valid_d = 1'b1; rdata_d = rsp_val; err_d = 1'b0;
                end else if (timeout_hit) begin
                    state_d = DONE; out_valid_d = 1'b1; rdata_d = 32'h0; err_d = 1'b1;
                end
            end
            default: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
        endcase
    end

    // State and output registers, cleared asynchronously on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mren_q      <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            cnt_q       <= '0;
            req_valid_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            out_valid_q <= 1'b0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mren_q      <= mren_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            req_valid_q <= req_valid_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            out_valid_q <= out_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: doc/lsu_access_unit.md
Name: lsu_access_unit

Overview:
- Load/store unit. Sits directly downstream of the instruction decoder and consumes its memory micro-fields (MREN, MWEN, UNSIGN).
- Turns one decoded load or store into a single word-aligned memory-bus transaction, using valid/ready handshakes on both sides.
- Performs byte-lane steering and write-strobe generation for stores, and lane extraction plus sign/zero extension for loads.
- Returns the result to writeback with an error flag.

Parameters:
- ADDR_W, 32, address width in bits.
- TIMEOUT_CYCLES, 255, maximum cycles to wait for a memory response. 0 disables the timeout.
- CNT_W, 8, width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decoded memory op valid
- in_ready  out  1  unit can accept a new op
- in_mren  in  2  00 none, 01 byte, 10 half, 11 word
- in_mwen  in  2  same encoding as in_mren, for stores
- in_unsign  in  1  zero-extend the load when 1
- in_addr  in  ADDR_W  effective address (ALU result)
- in_wdata  in  32  store data (rs2)
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus accepts the request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address, {in_addr[ADDR_W-1:2], 2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte write strobes (0 for reads)
- mem_rsp_valid  in  1  response valid (reads and writes)
- mem_rdata  in  32  raw read word
- out_valid  out  1  result valid
- out_ready  in  1  writeback consumes the result
- out_rdata  out  32  extended load data (0 for stores and errors)
- out_err  out  1  access error

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Reset enters IDLE.
- Reset values: mem_req_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, out_valid=0, out_rdata=0, out_err=0.
- in_ready is 1 exactly when the state is IDLE; it reads 1 while rst is held.
- IDLE:
  - On in_valid & in_ready, latch all in_* fields.
  - If mren≠0 and mwen≠0: go to DONE with out_err=1.
  - If both are 0 (no-op): go to DONE with out_rdata=0 and out_err=0.
  - Otherwise go to REQ.
- REQ:
  - Assert mem_req_valid. mem_we, mem_addr, mem_wdata and mem_wstrb stay stable until mem_req_ready.
  - On mem_req_ready, go to WAIT and clear the timeout counter.
  - If mem_rsp_valid is also high in that cycle, capture the response and go straight to DONE.
- WAIT:
  - The counter increments each cycle.
  - On mem_rsp_valid, capture the response and go to DONE.
  - If the counter reaches TIMEOUT_CYCLES (when nonzero) without a response, go to DONE with out_err=1 and out_rdata=0.
  - mem_rsp_valid wins over timeout in the same cycle.
- DONE:
  - out_valid=1. out_rdata and out_err hold until out_ready.
  - On out_ready, return to IDLE. The next op can be accepted one cycle later; no same-cycle re-accept.
- Store lanes (o = addr[1:0]):
  - Byte: wstrb = 4'b0001<<o, wdata = {4{wdata[7:0]}}.
  - Half: wstrb = 4'b0011<<{o[1],1'b0}, wdata = {2{wdata[15:0]}}.
  - Word: wstrb = 4'b1111, wdata unchanged.
- Load extract:
  - Byte: mem_rdata[8*o +: 8].
  - Half: mem_rdata[16*o[1] +: 16].
  - Word: full 32 bits.
  - The result is sign-extended unless unsign=1. unsign is ignored for word loads.
- Stores complete on mem_rsp_valid with out_rdata=0.
- mem_rsp_valid in IDLE, REQ (before handshake) or DONE is ignored.
- Reset mid-transaction:
  - All outputs return to reset values immediately (asynchronous).
  - A late response after reset is ignored.
  - No out_valid is produced for the abandoned op.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]≠0, issues no bus request. The unit goes IDLE→DONE with out_err=1 and out_rdata=0.
- Undefined: no misalignment check. A half access ignores addr[0]; a word access ignores addr[1:0]. Misalignment never raises out_err.

Test Plan:
- LB, addr=0x8000_0003, mem_rdata=0x80FF_1234, unsign=0 -> mem_addr=0x8000_0000, mem_wstrb=0, out_rdata=0xFFFF_FF80, out_err=0.
- LHU, addr=0x8000_0002, mem_rdata=0x9ABC_1234 -> out_rdata=0x0000_9ABC. Repeat with unsign=0 -> 0xFFFF_9ABC.
- SB, addr=0x8000_0001, wdata=0x1122_33A5, mem_req_ready held low 3 cycles -> request fields stable for those 3 cycles, mem_wstrb=4'b0010, mem_wdata=0xA5A5_A5A5, out_rdata=0 after the response.
- LW with no response, TIMEOUT_CYCLES=4 -> out_valid with out_err=1 on the 4th WAIT cycle. Hold out_ready=0 for 2 cycles -> outputs stay stable; in_ready=0 until the unit returns to IDLE.
- Zero-latency bus: mem_req_ready and mem_rsp_valid in the same cycle, LW, rdata=0xDEAD_BEEF -> out_valid next cycle, out_rdata=0xDEAD_BEEF.
- rst pulsed during WAIT, then a stale mem_rsp_valid -> no out_valid, in_ready=1. With LSU_MISALIGN_CHECK_EN, LW at 0x...2 -> mem_req_valid never asserted, out_err=1.
